rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL be clocked by a single clock and reset by an asynchronous, active-high reset, with ports as follows (clock and reset first).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 MEM_WB_reg_write  in  1  pipeline writeback request.
REQ-005 MEM_WB_rd  in  5  pipeline destination register.
REQ-006 RF_WR_Data  in  32  pipeline write data.
REQ-007 lt_valid  in  1  long-latency unit result valid.
REQ-008 lt_rd  in  5  long-latency destination register.
REQ-009 lt_data  in  32  long-latency result.
REQ-010 lt_ready  out  1  buffer can accept; asserted when FIFO count < 2.
REQ-011 trap_flush  in  1  discard all buffered long-latency results.
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_rd  out  5  register-file write address.
REQ-014 rf_wdata  out  32  register-file write data.
REQ-015 wb_stall  out  1  pipeline must hold its writeback inputs unchanged next cycle.
REQ-016 pending_mask  out  32  bit n set iff a buffered entry targets xn.

Function
REQ-017 Long-latency results SHALL be accepted into a 2-entry FIFO on lt_valid and lt_ready, or on lt_valid with count 2 and a same-cycle FIFO pop; accepted entries with lt_rd = 0 are dropped.
REQ-018 Port grant SHALL be combinational, with priority: FIFO head if wb_stall; else pipeline if MEM_WB_reg_write and MEM_WB_rd != 0; else FIFO head if non-empty; else none (rf_we = 0, rf_rd = 0, rf_wdata = 0).
REQ-019 wb_stall SHALL be 1 iff the FIFO is non-empty and any of the following holds: count = 2; starve counter = 3; or MEM_WB_reg_write with MEM_WB_rd matching any buffered rd (WAW).
REQ-020 Starve counter (2-bit) SHALL increment, saturating at 3, each cycle the FIFO is non-empty and the head is not granted; it SHALL clear on any head grant or when the FIFO is empty.
REQ-021 FSM states: EMPTY (count 0), PEND (count 1..2, no stall), DRAIN (wb_stall = 1).
REQ-022 FSM transitions: EMPTY->PEND on push; PEND->DRAIN when the REQ-019 condition is true; DRAIN->PEND/EMPTY after the head pops and the condition is cleared.
REQ-023 Simultaneous push and pop at count 2 SHALL keep count at 2, with no data loss.
REQ-024 trap_flush SHALL empty the FIFO and clear the starve counter at the next edge, and SHALL suppress both the FIFO grant and any same-cycle push; the pipeline grant is unaffected.
REQ-025 pending_mask SHALL be derived from the FIFO contents after the clock edge, giving one-cycle visibility after the push edge.
REQ-026 Pop latency: the head SHALL be written in the first cycle it wins the grant; the worst case from push is 4 cycles absent WAW.

Reset
REQ-027 Asserting rst SHALL immediately set count = 0, starve counter = 0, FSM = EMPTY, wb_stall = 0, lt_ready = 1, pending_mask = 0 and rf_we = 0.
REQ-028 Reset mid-operation SHALL discard all buffered entries without generating any write.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, FIFO_DEPTH = 2, STARVE_LIMIT = 3, and the entry struct {rd[4:0], data[31:0]}.
REQ-030 The FIFO SHALL be a sub-module named wb_pending_fifo (push, pop, flush, count, head, entries); arbitration and the FSM stay in rf_wb_arbiter.

Verification
REQ-031 Idle pipe: MEM_WB_reg_write = 1, rd = 5, data = 0xDEADBEEF, FIFO empty -> rf_we = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF, wb_stall = 0.
REQ-032 Starvation: push lt rd = 7, data = 0x11, then 3 cycles of pipeline writes to rd = 3 -> wb_stall = 1 in the 4th cycle, rf_rd = 7, rf_wdata = 0x11; next cycle the pipeline write to rd = 3 completes.
REQ-033 Full: push rd = 8 then rd = 9 with the pipe busy -> lt_ready = 0 and wb_stall = 1; the writes issue in order 8 then 9, and pending_mask goes 0x300 -> 0x200 -> 0.
REQ-034 WAW: buffer rd = 10, pipeline write rd = 10 -> stall; the lt write issues first, then the pipe write, so the final value is the pipe data.
REQ-035 Flush: two entries buffered, trap_flush = 1 -> no lt writes, count = 0 and pending_mask = 0 next cycle; lt_valid with rd = 0 -> entry dropped, no write.
REQ-036 Reset: rst asserted mid-DRAIN -> rf_we = 0 and lt_ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared state enum, FIFO depth, starve limit and pending-entry struct
package rf_wb_arbiter_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] STARVE_LIMIT = 2'd3;
  typedef enum logic [1:0] {EMPTY, PEND, DRAIN} wb_state_e;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo: 2-entry shift FIFO of long-latency results (push/pop/flush in; count, head, entries out)
module wb_pending_fifo
  import rf_wb_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  input  logic                             flush,
  output logic [1:0]                       count,
  output wb_entry_t                        head,
  output wb_entry_t [FIFO_DEPTH-1:0]       entries
);
  wb_entry_t [FIFO_DEPTH-1:0] mem;
  logic [1:0] wr_idx;
  assign wr_idx = count - {1'b0, pop};
  assign head = mem[0];
  assign entries = mem;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      mem   <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop) mem[0] <= mem[1];
      if (push) mem[wr_idx[0]] <= push_entry;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates the register-file write port between the MEM/WB pipeline and buffered long-latency results
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_WB_reg_write,
  input  logic [4:0]  MEM_WB_rd,
  input  logic [31:0] RF_WR_Data,
  input  logic        lt_valid,
  input  logic [4:0]  lt_rd,
  input  logic [31:0] lt_data,
  output logic        lt_ready,
  input  logic        trap_flush,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        wb_stall,
  output logic [31:0] pending_mask
);
  wb_state_e state, state_d;
  logic [1:0] count, cnt_d, starve, starve_d;
  wb_entry_t head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic nonempty, pipe_req, waw, head_grant, pipe_grant, push, pop;
  wb_pending_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_entry('{rd: lt_rd, data: lt_data}),
    .pop(pop),
    .flush(trap_flush),
    .count(count),
    .head(head),
    .entries(entries)
  );
  assign nonempty = count != 2'd0;
  assign lt_ready = count < 2'(FIFO_DEPTH);
  assign pending_mask = (nonempty ? 32'd1 << entries[0].rd : 32'd0) | (count == 2'd2 ? 32'd1 << entries[1].rd : 32'd0);
  assign pipe_req = MEM_WB_reg_write && MEM_WB_rd != 5'd0;
  assign waw = MEM_WB_reg_write && pending_mask[MEM_WB_rd];
  assign push = lt_valid && lt_rd != 5'd0 && !trap_flush && (lt_ready || pop);
  assign pop = head_grant;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      starve <= 2'd0;
    end else begin
      state  <= state_d;
      starve <= starve_d;
    end
  end
  // DRAIN captures the registered stall causes (full, starved); WAW depends on live pipeline inputs
  always_comb begin
    wb_stall   = state == DRAIN || (nonempty && waw);
    head_grant = !rst && !trap_flush && (wb_stall || (!pipe_req && nonempty));
    pipe_grant = !rst && !wb_stall && pipe_req;
    rf_we      = head_grant || pipe_grant;
    rf_rd      = head_grant ? head.rd : pipe_grant ? MEM_WB_rd : 5'd0;
    rf_wdata   = head_grant ? head.data : pipe_grant ? RF_WR_Data : 32'd0;
    starve_d   = (trap_flush || !nonempty || head_grant) ? 2'd0 : (starve == STARVE_LIMIT ? starve : starve + 2'd1);
    cnt_d      = trap_flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    state_d    = cnt_d == 2'd0 ? EMPTY : (cnt_d == 2'(FIFO_DEPTH) || starve_d == STARVE_LIMIT) ? DRAIN : PEND;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic clk = 0, rst = 1;
  logic MEM_WB_reg_write, lt_valid, trap_flush;
  logic [4:0] MEM_WB_rd, lt_rd, rf_rd;
  logic [31:0] RF_WR_Data, lt_data, rf_wdata, pending_mask;
  logic lt_ready, rf_we, wb_stall;
  logic [36:0] sb[$];
  logic [36:0] exp_e;
  int n_chk = 0, n_fail = 0;
  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_rd(MEM_WB_rd), .RF_WR_Data(RF_WR_Data),
    .lt_valid(lt_valid), .lt_rd(lt_rd), .lt_data(lt_data), .lt_ready(lt_ready),
    .trap_flush(trap_flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .pending_mask(pending_mask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic exp_w(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back({rd, d});
  endtask
  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld, input logic fl);
    MEM_WB_reg_write = pw; MEM_WB_rd = prd; RF_WR_Data = pd;
    lt_valid = lv; lt_rd = lrd; lt_data = ld; trap_flush = fl;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t", rf_rd, rf_wdata, $time);
      end else begin
        exp_e = sb.pop_front();
        if ({rf_rd, rf_wdata} !== exp_e) begin
          n_fail++;
          $display("FAIL write_order: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h at %0t",
                   rf_rd, rf_wdata, exp_e[36:32], exp_e[31:0], $time);
        end
      end
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_ready", lt_ready, 1);
    chk("rst_stall", wb_stall, 0);
    chk("rst_mask", pending_mask, 0);
    @(posedge clk);
    nxt;
    rst = 0;
    exp_w(5, 32'hDEADBEEF);
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_we", rf_we, 1);
    chk("idle_rd", rf_rd, 5);
    chk("idle_data", rf_wdata, 32'hDEADBEEF);
    chk("idle_stall", wb_stall, 0);
    nxt;
    exp_w(3, 32'hA1); exp_w(3, 32'hA2); exp_w(3, 32'hA3); exp_w(7, 32'h11); exp_w(3, 32'hA4);
    drive(0, 0, 0, 1, 7, 32'h11, 0);
    @(negedge clk);
    chk("starve_push_nowrite", rf_we, 0);
    nxt;
    drive(1, 3, 32'hA1, 0, 0, 0, 0);
    @(negedge clk);
    chk("starve_mask", pending_mask, 32'h80);
    nxt;
    drive(1, 3, 32'hA2, 0, 0, 0, 0);
    nxt;
    drive(1, 3, 32'hA3, 0, 0, 0, 0);
    @(negedge clk);
    chk("starve_c3_stall", wb_stall, 0);
    nxt;
    drive(1, 3, 32'hA4, 0, 0, 0, 0);
    @(negedge clk);
    chk("starve_stall", wb_stall, 1);
    chk("starve_rd", rf_rd, 7);
    chk("starve_data", rf_wdata, 32'h11);
    nxt;
    @(negedge clk);
    chk("starve_after_stall", wb_stall, 0);
    chk("starve_pipe_rd", rf_rd, 3);
    nxt;
    exp_w(1, 32'hB0); exp_w(1, 32'hB1); exp_w(8, 32'h88); exp_w(1, 32'hB2); exp_w(9, 32'h99);
    drive(1, 1, 32'hB0, 1, 8, 32'h88, 0);
    nxt;
    drive(1, 1, 32'hB1, 1, 9, 32'h99, 0);
    @(negedge clk);
    chk("full_ready_c1", lt_ready, 1);
    chk("full_mask_c1", pending_mask, 32'h100);
    nxt;
    drive(1, 1, 32'hB2, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_ready", lt_ready, 0);
    chk("full_stall", wb_stall, 1);
    chk("full_mask", pending_mask, 32'h300);
    chk("full_rd8", rf_rd, 8);
    nxt;
    @(negedge clk);
    chk("full_mask_after8", pending_mask, 32'h200);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_rd9", rf_rd, 9);
    nxt;
    @(negedge clk);
    chk("full_mask_empty", pending_mask, 0);
    exp_w(10, 32'h10A); exp_w(10, 32'hAA);
    nxt;
    drive(0, 0, 0, 1, 10, 32'h10A, 0);
    nxt;
    drive(1, 10, 32'hAA, 0, 0, 0, 0);
    @(negedge clk);
    chk("waw_stall", wb_stall, 1);
    chk("waw_rd", rf_rd, 10);
    chk("waw_data", rf_wdata, 32'h10A);
    nxt;
    @(negedge clk);
    chk("waw_release", wb_stall, 0);
    chk("waw_final", rf_wdata, 32'hAA);
    nxt;
    exp_w(2, 32'hD0); exp_w(2, 32'hD1); exp_w(2, 32'hD2);
    drive(1, 2, 32'hD0, 1, 12, 32'hC0, 0);
    nxt;
    drive(1, 2, 32'hD1, 1, 13, 32'hC1, 0);
    nxt;
    drive(1, 2, 32'hD2, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_mask_pre", pending_mask, 32'h3000);
    chk("flush_no_write", rf_we, 0);
    nxt;
    drive(1, 2, 32'hD2, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_mask", pending_mask, 0);
    chk("flush_ready", lt_ready, 1);
    chk("flush_pipe_rd", rf_rd, 2);
    nxt;
    drive(0, 0, 0, 1, 0, 32'h55, 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd0_mask", pending_mask, 0);
    chk("rd0_no_write", rf_we, 0);
    nxt;
    exp_w(4, 32'hE0); exp_w(4, 32'hE1);
    drive(1, 4, 32'hE0, 1, 20, 32'h20, 0);
    nxt;
    drive(1, 4, 32'hE1, 1, 21, 32'h21, 0);
    nxt;
    drive(1, 4, 32'hE2, 0, 0, 0, 0);
    #1;
    chk("drain_stall", wb_stall, 1);
    rst = 1;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_ready", lt_ready, 1);
    chk("arst_stall", wb_stall, 0);
    chk("arst_mask", pending_mask, 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    repeat (4) nxt;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
